// File: rtl/pudding_chain_loader.sv
// Purpose : byte-command sequencer for the DAC daisy chain + state register pair (load, readback, clear, enable).
// Latency : LOAD 145 cycles accept->commit edge, CLEAR 129, READBACK 1+NBYTES*9 with no stalls; SET_EN 1 cycle.
// Backpress: commands held off while busy; wr_valid low stalls in LOAD_WAIT, rd_ready low stalls in RB_OUT, indefinitely.
//
// Ports:
//   clk, rst                         clock / synchronous active-high reset
//   cmd_valid/cmd_ready/cmd_op/cmd_arg  command channel (00 LOAD, 01 READBACK, 10 CLEAR, 11 SET_EN)
//   wr_valid/wr_ready/wr_data        load byte stream, MSB shifted first, byte 0 lands in chain[top]
//   rd_valid/rd_ready/rd_data        readback byte stream, first sampled bit in rd_data[7]
//   chain_msb                        last bit of the chain (bit about to leave on a shift edge)
//   datum, shift, transfer, dir      bit-level chain control (dir 1: chain->state, 0: state->chain)
//   dac_en, busy                     DAC state-enable, sequencer not idle
module pudding_chain_loader #(
  parameter int CHAIN_LEN = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic       cmd_arg,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  output logic       rd_valid,
  input  logic       rd_ready,
  output logic [7:0] rd_data,
  input  logic       chain_msb,
  output logic       datum,
  output logic       shift,
  output logic       transfer,
  output logic       dir,
  output logic       dac_en,
  output logic       busy
);

  localparam int NBYTES = CHAIN_LEN / 8;
  localparam int BYTE_W = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(NBYTES - 1);

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_RB     = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_SET_EN = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_WAIT,
    S_LOAD_SHIFT,
    S_COMMIT,
    S_RB_XFER,
    S_RB_SHIFT,
    S_RB_OUT,
    S_CLR_SHIFT
  } state_t;

  state_t            state_q, state_d;
  logic [2:0]        bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]        wr_byte_q, wr_byte_d;
  logic [7:0]        rd_data_d;
  logic              dac_en_d;
  logic              datum_q, datum_d;
  logic              cmd_ready_d, wr_ready_d, rd_valid_d;
  logic              shift_d, transfer_d, dir_d, busy_d;

  // During readback the recirculated bit must be the one leaving on the same
  // edge; a registered copy would lag by one bit and corrupt the chain, so
  // datum forwards chain_msb there and is registered everywhere else.
  assign datum = (state_q == S_RB_SHIFT) ? chain_msb : datum_q;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    byte_cnt_d = byte_cnt_q;
    wr_byte_d  = wr_byte_q;
    rd_data_d  = rd_data;
    dac_en_d   = dac_en;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          bit_cnt_d  = 3'd0;
          byte_cnt_d = '0;
          case (cmd_op)
            OP_LOAD:   state_d = S_LOAD_WAIT;
            OP_RB:     state_d = S_RB_XFER;
            OP_CLEAR:  state_d = S_CLR_SHIFT;
            OP_SET_EN: dac_en_d = cmd_arg;
            default:   state_d = S_IDLE;
          endcase
        end
      end

      S_LOAD_WAIT: begin
        if (wr_valid && wr_ready) begin
          wr_byte_d = wr_data;
          bit_cnt_d = 3'd0;
          state_d   = S_LOAD_SHIFT;
        end
      end

      S_LOAD_SHIFT: begin
        if (bit_cnt_q == 3'd7) begin
          bit_cnt_d = 3'd0;
          if (byte_cnt_q == LAST_BYTE) begin
            state_d = S_COMMIT;
          end else begin
            byte_cnt_d = byte_cnt_q + BYTE_W'(1);
            state_d    = S_LOAD_WAIT;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end

      S_COMMIT: begin
        bit_cnt_d  = 3'd0;
        byte_cnt_d = '0;
        state_d    = S_IDLE;
      end

      S_RB_XFER: begin
        bit_cnt_d  = 3'd0;
        byte_cnt_d = '0;
        state_d    = S_RB_SHIFT;
      end

      S_RB_SHIFT: begin
        rd_data_d = {rd_data[6:0], chain_msb};
        if (bit_cnt_q == 3'd7) begin
          bit_cnt_d = 3'd0;
          state_d   = S_RB_OUT;
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end

      S_RB_OUT: begin
        if (rd_valid && rd_ready) begin
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            state_d    = S_IDLE;
          end else begin
            byte_cnt_d = byte_cnt_q + BYTE_W'(1);
            state_d    = S_RB_SHIFT;
          end
        end
      end

      // {byte_cnt, bit_cnt} doubles as the CHAIN_LEN-cycle clear counter.
      S_CLR_SHIFT: begin
        if (bit_cnt_q == 3'd7) begin
          bit_cnt_d = 3'd0;
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            state_d    = S_COMMIT;
          end else begin
            byte_cnt_d = byte_cnt_q + BYTE_W'(1);
          end
        end else begin
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so the registered copies line
    // up with the state register in the cycle they apply to.
    cmd_ready_d = (state_d == S_IDLE);
    busy_d      = (state_d != S_IDLE);
    wr_ready_d  = (state_d == S_LOAD_WAIT);
    rd_valid_d  = (state_d == S_RB_OUT);
    shift_d     = (state_d == S_LOAD_SHIFT) || (state_d == S_RB_SHIFT) ||
                  (state_d == S_CLR_SHIFT);
    transfer_d  = (state_d == S_COMMIT) || (state_d == S_RB_XFER);
    dir_d       = (state_d == S_COMMIT);
    datum_d     = (state_d == S_LOAD_SHIFT) ? wr_byte_d[~bit_cnt_d] : 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= 3'd0;
      byte_cnt_q <= '0;
      wr_byte_q  <= 8'd0;
      rd_data    <= 8'd0;
      dac_en     <= 1'b0;
      datum_q    <= 1'b0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      wr_ready   <= 1'b0;
      rd_valid   <= 1'b0;
      shift      <= 1'b0;
      transfer   <= 1'b0;
      dir        <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      wr_byte_q  <= wr_byte_d;
      rd_data    <= rd_data_d;
      dac_en     <= dac_en_d;
      datum_q    <= datum_d;
      cmd_ready  <= cmd_ready_d;
      busy       <= busy_d;
      wr_ready   <= wr_ready_d;
      rd_valid   <= rd_valid_d;
      shift      <= shift_d;
      transfer   <= transfer_d;
      dir        <= dir_d;
    end
  end

endmodule

// File: tb/tb_pudding_chain_loader.sv
// Bench for pudding_chain_loader: a downstream chain/state-register model
// reacting to the DUT, a frame-level expectation (what the state register
// and the readback bytes must hold) and per-cycle protocol checks.
module tb_pudding_chain_loader;

  localparam logic [1:0] OP_LOAD  = 2'b00;
  localparam logic [1:0] OP_RB    = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_SET   = 2'b11;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_arg;
  logic [1:0] cmd_op;
  logic       wr_valid, wr_ready;
  logic [7:0] wr_data;
  logic       rd_valid, rd_ready;
  logic [7:0] rd_data;
  logic       chain_msb, datum, shift, transfer, dir, dac_en, busy;

  pudding_chain_loader #(.CHAIN_LEN(128)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_arg(cmd_arg),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .chain_msb(chain_msb), .datum(datum), .shift(shift), .transfer(transfer),
    .dir(dir), .dac_en(dac_en), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- downstream chain + state register ----------------
  logic [127:0] chain_m = '0;
  logic [127:0] state_m = '0;
  assign chain_msb = chain_m[127];

  int cyc = 0, shift_tot = 0, commit_tot = 0, rbx_tot = 0;
  int last_acc_cyc = 0, last_commit_cyc = 0, last_rd_cyc = 0, rd_n = 0;
  logic [7:0] rd_log [0:255];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (shift) begin
      chain_m   <= {chain_m[126:0], datum};
      shift_tot <= shift_tot + 1;
    end
    if (transfer) begin
      if (dir) begin
        state_m         <= chain_m;
        commit_tot      <= commit_tot + 1;
        last_commit_cyc <= cyc;
      end else begin
        chain_m <= state_m;
        rbx_tot <= rbx_tot + 1;
      end
    end
    if (!rst && cmd_valid && cmd_ready) last_acc_cyc <= cyc;
    if (!rst && rd_valid && rd_ready) begin
      rd_log[rd_n % 256] <= rd_data;
      rd_n               <= rd_n + 1;
      last_rd_cyc        <= cyc;
    end
  end

  // ---------------- per-cycle compare ----------------
  logic [127:0] ld_frame = '0;  // frame of the LOAD in flight, byte 0 at [127:120]
  logic [1:0]   mode = OP_SET;
  int           sh_idx = 0;
  logic         pv_valid = 1'b0, pv_ready = 1'b0;
  logic [7:0]   pv_data = 8'd0;

  always @(negedge clk) begin
    if (rst) begin
      pv_valid = 1'b0;
    end else begin
      chk("ready_vs_busy", cmd_ready, !busy);
      if (wr_ready || rd_valid || cmd_ready) chk("no_shift_when_waiting", shift, 1'b0);
      if (transfer) chk("transfer_without_shift", shift, 1'b0);
      if (pv_valid && !pv_ready) begin
        chk("rd_valid_held", rd_valid, 1'b1);
        chk("rd_data_stable", rd_data, pv_data);
      end
      if (shift) begin
        case (mode)
          OP_LOAD:  if (sh_idx < 128) chk("load_datum", datum, ld_frame[127 - sh_idx]);
                    else chk("load_extra_shift", shift, 1'b0);
          OP_RB:    chk("readback_recirculate", datum, chain_msb);
          OP_CLEAR: chk("clear_datum", datum, 1'b0);
          default:  chk("shift_after_set_en", shift, 1'b0);
        endcase
        sh_idx++;
      end
      if (cmd_valid && cmd_ready) begin
        mode   = cmd_op;
        sh_idx = 0;
      end
      pv_valid = rd_valid;
      pv_ready = rd_ready;
      pv_data  = rd_data;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic issue_cmd(input logic [1:0] op, input logic arg);
    int n = 0;
    cmd_op = op; cmd_arg = arg; cmd_valid = 1'b1;
    while (!cmd_ready && n < 400) begin @(posedge clk); #1; n++; end
    chk("cmd_accept_wait", cmd_ready, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int stall);
    int n = 0;
    while (!wr_ready && n < 100) begin @(posedge clk); #1; n++; end
    chk("wr_ready_wait", wr_ready, 1'b1);
    repeat (stall) begin @(posedge clk); #1; end
    wr_data = b; wr_valid = 1'b1;
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!cmd_ready && n < 400) begin @(posedge clk); #1; n++; end
    chk("idle_wait", cmd_ready, 1'b1);
  endtask

  task automatic do_load(input logic [127:0] f, input int stall_odd);
    ld_frame = f;
    issue_cmd(OP_LOAD, 1'b0);
    for (int k = 0; k < 16; k++) send_byte(f[127 - 8*k -: 8], (k % 2 == 1) ? stall_odd : 0);
    wait_idle();
  endtask

  // Collects 16 bytes (command already issued) and checks them against exp.
  task automatic do_readback(input int stall, input logic [127:0] exp);
    int n;
    int base = rd_n;
    for (int k = 0; k < 16; k++) begin
      n = 0;
      while (!rd_valid && n < 100) begin @(posedge clk); #1; n++; end
      chk("rd_valid_wait", rd_valid, 1'b1);
      if (stall > 0) begin
        rd_ready = 1'b0;
        repeat (stall) begin @(posedge clk); #1; end
        rd_ready = 1'b1;
      end
      @(posedge clk); #1;
      if (stall > 0) rd_ready = 1'b0;
    end
    wait_idle();
    chk("rd_byte_count", rd_n - base, 16);
    for (int k = 0; k < 16; k++) chk("rd_byte", rd_log[(base + k) % 256], exp[127 - 8*k -: 8]);
  endtask

  // ---------------- main sequence ----------------
  logic [127:0] f1, f3, f7, t1_state;
  int s0, c0, r0, n;

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_arg = 1'b0;
    wr_valid = 1'b0; wr_data = 8'd0; rd_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    chk("reset_cmd_ready", cmd_ready, 1'b1);
    chk("reset_busy", busy, 1'b0);
    chk("reset_shift", shift, 1'b0);
    chk("reset_transfer", transfer, 1'b0);
    chk("reset_wr_ready", wr_ready, 1'b0);
    chk("reset_rd_valid", rd_valid, 1'b0);
    chk("reset_rd_data", rd_data, 8'd0);
    chk("reset_dac_en", dac_en, 1'b0);

    // T1: corner-bit frame, no stalls
    f1 = {8'h80, 112'h0, 8'h01};
    s0 = shift_tot; c0 = commit_tot; r0 = rbx_tot;
    do_load(f1, 0);
    chk("t1_shift_count", shift_tot - s0, 128);
    chk("t1_commit_count", commit_tot - c0, 1);
    chk("t1_no_readback_xfer", rbx_tot - r0, 0);
    chk("t1_latency", last_commit_cyc - last_acc_cyc, 145);
    chk("t1_state_literal", state_m, {1'b1, 126'b0, 1'b1});
    chk("t1_dac_en", dac_en, 1'b0);
    t1_state = state_m;

    // T2: clear
    s0 = shift_tot; c0 = commit_tot;
    issue_cmd(OP_CLEAR, 1'b0);
    wait_idle();
    chk("t2_shift_count", shift_tot - s0, 128);
    chk("t2_commit_count", commit_tot - c0, 1);
    chk("t2_latency", last_commit_cyc - last_acc_cyc, 129);
    chk("t2_state_zero", state_m, 128'h0);

    // T3: SET_EN
    issue_cmd(OP_SET, 1'b1);
    chk("t3_dac_en_next_cycle", dac_en, 1'b1);
    chk("t3_stays_idle", cmd_ready, 1'b1);

    // T4: same frame with wr_valid withheld on every other byte
    s0 = shift_tot;
    do_load(f1, 3);
    chk("t4_shift_count", shift_tot - s0, 128);
    chk("t4_same_as_unstalled", state_m, t1_state);

    // T5: load then readback with rd_ready stalls
    f3 = '0;
    f3[127:112] = 16'hA53C;
    for (int i = 2; i < 16; i++) f3[127 - 8*i -: 8] = 8'(i * 37 + 11);
    do_load(f3, 0);
    chk("t5_state_loaded", state_m, f3);
    s0 = shift_tot; c0 = commit_tot; r0 = rbx_tot;
    issue_cmd(OP_RB, 1'b0);
    do_readback(5, f3);
    chk("t5_first_byte_literal", rd_log[(rd_n - 16) % 256], 8'hA5);
    chk("t5_second_byte_literal", rd_log[(rd_n - 15) % 256], 8'h3C);
    chk("t5_one_rb_xfer", rbx_tot - r0, 1);
    chk("t5_no_commit", commit_tot - c0, 0);
    chk("t5_shift_count", shift_tot - s0, 128);
    chk("t5_chain_restored", chain_m, state_m);

    // T6: readback with rd_ready held high
    rd_ready = 1'b1;
    issue_cmd(OP_RB, 1'b0);
    do_readback(0, f3);
    rd_ready = 1'b0;
    chk("t6_latency", last_rd_cyc - last_acc_cyc, 145);
    chk("t6_dac_en_kept", dac_en, 1'b1);

    // T7: READBACK presented during LOAD_SHIFT is held off, then taken
    f7 = ~f3;
    ld_frame = f7;
    issue_cmd(OP_LOAD, 1'b0);
    fork
      begin
        for (int k = 0; k < 16; k++) send_byte(f7[127 - 8*k -: 8], 0);
      end
      begin
        repeat (20) begin @(posedge clk); #1; end
        n = 0;
        while (!shift && n < 20) begin @(posedge clk); #1; n++; end
        chk("t7_in_load_shift", shift, 1'b1);
        chk("t7_held_off_ready", cmd_ready, 1'b0);
        issue_cmd(OP_RB, 1'b0);
      end
    join
    chk("t7_accept_after_commit", last_acc_cyc - last_commit_cyc, 1);
    do_readback(1, f7);
    chk("t7_state", state_m, f7);

    // T8: reset during byte 7 of a LOAD
    c0 = commit_tot; r0 = rbx_tot;
    ld_frame = f1;
    issue_cmd(OP_LOAD, 1'b0);
    for (int k = 0; k < 8; k++) send_byte(f1[127 - 8*k -: 8], 0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("t8_cmd_ready", cmd_ready, 1'b1);
    chk("t8_busy", busy, 1'b0);
    chk("t8_shift", shift, 1'b0);
    chk("t8_transfer", transfer, 1'b0);
    chk("t8_dir", dir, 1'b0);
    chk("t8_datum", datum, 1'b0);
    chk("t8_wr_ready", wr_ready, 1'b0);
    chk("t8_rd_valid", rd_valid, 1'b0);
    chk("t8_rd_data", rd_data, 8'd0);
    chk("t8_dac_en", dac_en, 1'b0);
    rst = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("t8_no_commit", commit_tot - c0, 0);
    chk("t8_no_rb_xfer", rbx_tot - r0, 0);
    chk("t8_state_kept", state_m, f7);
    do_load(f1, 0);
    chk("t8_reload_state", state_m, f1);
    chk("t8_reload_latency", last_commit_cyc - last_acc_cyc, 145);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d of %0d checks", errors, checks);
    $fatal(1);
  end

endmodule
